// File: rtl/mem_subword_adapter_if.sv
// ---------------------------------------------------------------------------
// mem_subword_adapter_if
//   Core-side request/response bus of the sub-word memory adapter.
//   The core drives requests and accepts responses (master); the adapter
//   accepts requests and returns responses (slave).
//
//   req_valid/req_ready     request handshake
//   req_store               1 = store, 0 = load
//   req_size                0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_unsigned            loads zero-extend when 1, sign-extend when 0
//   req_address             byte address
//   req_data                right-justified store data
//   resp_valid/resp_ready   response handshake
//   resp_data               extended load data, 0 for stores
//   resp_exception          misaligned, illegal size or memory fault
// ---------------------------------------------------------------------------
interface mem_subword_adapter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [31:0]           req_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_data;
  logic                  resp_exception;

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_address, req_data,
    output resp_ready,
    input  req_ready, resp_valid, resp_data, resp_exception
  );

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_address, req_data,
    input  resp_ready,
    output req_ready, resp_valid, resp_data, resp_exception
  );
endinterface

// File: rtl/mem_subword_adapter.sv
// ---------------------------------------------------------------------------
// mem_subword_adapter
//   Turns core byte/half/word loads and stores into aligned 32-bit word
//   accesses on a word-only memory. Loads extract and extend the addressed
//   lane; sub-word stores do a read-modify-write. Misaligned or illegal
//   requests are answered with an exception and never touch memory.
//   One request is outstanding at a time.
//
//   CLK                  rising-edge clock
//   RESET                asynchronous, active-low reset
//   core                 request/response bus (slave side)
//   mem_read_address     word-aligned read address (latched request address)
//   mem_read_data        combinational read data from memory
//   mem_read_exception   memory read fault
//   mem_write_enable     one-cycle write strobe
//   mem_write_address    word-aligned write address
//   mem_write_data       merged word to write
//   mem_write_exception  memory write fault
// ---------------------------------------------------------------------------
module mem_subword_adapter #(
  parameter int ADDR_WIDTH           = 32,
  parameter bit WORD_STORE_SKIP_READ = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  mem_subword_adapter_if.slave  core,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [31:0]           mem_read_data,
  input  logic                  mem_read_exception,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [31:0]           mem_write_data,
  input  logic                  mem_write_exception
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RSP  = 2'd3;

  logic [1:0]            state_q,     state_d;
  logic                  ready_en_q,  ready_en_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [1:0]            lane_q,      lane_d;
  logic [1:0]            size_q,      size_d;
  logic                  store_q,     store_d;
  logic                  unsigned_q,  unsigned_d;
  logic [31:0]           wdata_q,     wdata_d;
  logic [31:0]           merged_q,    merged_d;
  logic [31:0]           resp_data_q, resp_data_d;
  logic                  resp_exc_q,  resp_exc_d;

  logic                  req_fire;
  logic                  req_bad;
  logic                  req_skip_read;
  logic [4:0]            shamt;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           byte_mask;
  logic [31:0]           load_val;
  logic [31:0]           store_val;

  // req_ready only rises on the first edge after reset release
  assign core.req_ready      = (state_q == ST_IDLE) && ready_en_q;
  assign core.resp_valid     = (state_q == ST_RSP);
  assign core.resp_data      = resp_data_q;
  assign core.resp_exception = resp_exc_q;

  // Write strobe decodes straight from state, so an async reset kills it at once
  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_write_enable  = (state_q == ST_WR);
  assign mem_write_data    = merged_q;

  assign req_fire = core.req_valid && core.req_ready;

  assign req_bad = (core.req_size == 2'd3) ||
                   ((core.req_size == 2'd1) && core.req_address[0]) ||
                   ((core.req_size == 2'd2) && (core.req_address[1:0] != 2'b00));

  assign req_skip_read = WORD_STORE_SKIP_READ && core.req_store && (core.req_size == 2'd2);

  assign shamt = {lane_q, 3'b000};

  // Lane extraction for loads and lane merge for stores, both from the word
  // the memory presents during RD
  always_comb begin
    rd_byte   = 8'(mem_read_data >> shamt);
    rd_half   = lane_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    byte_mask = 32'h0000_00FF << shamt;

    case (size_q)
      2'd0:    load_val = unsigned_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'd1:    load_val = unsigned_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_val = mem_read_data;
    endcase

    case (size_q)
      2'd0:    store_val = (mem_read_data & ~byte_mask) | ({24'd0, wdata_q[7:0]} << shamt);
      2'd1:    store_val = lane_q[1] ? {wdata_q[15:0], mem_read_data[15:0]}
                                     : {mem_read_data[31:16], wdata_q[15:0]};
      default: store_val = wdata_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ready_en_d  = 1'b1;
    addr_d      = addr_q;
    lane_d      = lane_q;
    size_d      = size_q;
    store_d     = store_q;
    unsigned_d  = unsigned_q;
    wdata_d     = wdata_q;
    merged_d    = merged_q;
    resp_data_d = resp_data_q;
    resp_exc_d  = resp_exc_q;

    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          addr_d      = {core.req_address[ADDR_WIDTH-1:2], 2'b00};
          lane_d      = core.req_address[1:0];
          size_d      = core.req_size;
          store_d     = core.req_store;
          unsigned_d  = core.req_unsigned;
          wdata_d     = core.req_data;
          resp_data_d = 32'd0;
          resp_exc_d  = 1'b0;
          if (req_bad) begin
            resp_exc_d = 1'b1;
            state_d    = ST_RSP;
          end else if (req_skip_read) begin
            merged_d = core.req_data;
            state_d  = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end

      ST_RD: begin
        if (mem_read_exception) begin
          resp_exc_d = 1'b1;
          state_d    = ST_RSP;
        end else if (!store_q) begin
          resp_data_d = load_val;
          state_d     = ST_RSP;
        end else begin
          merged_d = store_val;
          state_d  = ST_WR;
        end
      end

      ST_WR: begin
        resp_exc_d = resp_exc_q | mem_write_exception;
        state_d    = ST_RSP;
      end

      default: begin
        if (core.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      ready_en_q  <= 1'b0;
      addr_q      <= '0;
      lane_q      <= 2'd0;
      size_q      <= 2'd0;
      store_q     <= 1'b0;
      unsigned_q  <= 1'b0;
      wdata_q     <= 32'd0;
      merged_q    <= 32'd0;
      resp_data_q <= 32'd0;
      resp_exc_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_en_q  <= ready_en_d;
      addr_q      <= addr_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      store_q     <= store_d;
      unsigned_q  <= unsigned_d;
      wdata_q     <= wdata_d;
      merged_q    <= merged_d;
      resp_data_q <= resp_data_d;
      resp_exc_q  <= resp_exc_d;
    end
  end

endmodule

// File: tb/tb_mem_subword_adapter.sv
// ---------------------------------------------------------------------------
// tb_mem_subword_adapter
//   Directed bench for mem_subword_adapter with a small word memory model.
// ---------------------------------------------------------------------------
module tb_mem_subword_adapter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] mem_read_address;
  logic [31:0] mem_read_data;
  logic        mem_read_exception;
  logic        mem_write_enable;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic        mem_write_exception;

  logic [31:0] mem [0:1023];
  logic        load_en;
  logic [9:0]  load_idx;
  logic [31:0] load_val;
  int          wr_count = 0;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  int checks   = 0;
  int failures = 0;

  mem_subword_adapter_if #(.ADDR_WIDTH(32)) core_bus ();

  mem_subword_adapter #(
    .ADDR_WIDTH          (32),
    .WORD_STORE_SKIP_READ(1'b1)
  ) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .core               (core_bus),
    .mem_read_address   (mem_read_address),
    .mem_read_data      (mem_read_data),
    .mem_read_exception (mem_read_exception),
    .mem_write_enable   (mem_write_enable),
    .mem_write_address  (mem_write_address),
    .mem_write_data     (mem_write_data),
    .mem_write_exception(mem_write_exception)
  );

  // 10-unit clock; outputs are sampled 1 unit after each rising edge
  always #5 CLK = ~CLK;

  assign mem_read_data = mem[mem_read_address[11:2]];

  // Memory model: preload port for setup, otherwise the adapter's write strobe
  always @(posedge CLK) begin
    if (load_en) begin
      mem[load_idx] <= load_val;
    end else if (mem_write_enable) begin
      mem[mem_write_address[11:2]] <= mem_write_data;
      wr_count <= wr_count + 1;
      wr_addr  <= mem_write_address;
      wr_data  <= mem_write_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // Issues one request and returns once resp_valid is seen (or a bound expires).
  // lat counts edges from the accepting edge (=1) to the first edge after
  // which resp_valid is high.
  task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic un,
                               input logic [31:0] a, input logic [31:0] d,
                               output int lat, output logic [31:0] rdata,
                               output logic rexc, output int writes);
    int w0;
    int n;
    w0 = wr_count;
    core_bus.req_valid    = 1'b1;
    core_bus.req_store    = st;
    core_bus.req_size     = sz;
    core_bus.req_unsigned = un;
    core_bus.req_address  = a;
    core_bus.req_data     = d;
    n = 0;
    while (!core_bus.req_ready && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!core_bus.req_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
    core_bus.req_valid = 1'b0;
    lat = 1;
    while (!core_bus.resp_valid && lat < 12) begin
      @(posedge CLK); #1;
      lat++;
    end
    rdata  = core_bus.resp_data;
    rexc   = core_bus.resp_exception;
    writes = wr_count - w0;
  endtask

  task automatic finishResp(input string tag);
    core_bus.resp_ready = 1'b1;
    @(posedge CLK); #1;
    checkOutput({tag, "_drop"}, {31'd0, core_bus.resp_valid}, 32'd0);
  endtask

  task automatic runCase(input string tag, input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] d,
                         input int exp_lat, input logic [31:0] exp_data,
                         input logic exp_exc, input int exp_writes);
    int          lat;
    logic [31:0] rdata;
    logic        rexc;
    int          writes;
    applyStimulus(st, sz, un, a, d, lat, rdata, rexc, writes);
    checkOutput({tag, "_lat"},    32'(lat), 32'(exp_lat));
    checkOutput({tag, "_data"},   rdata, exp_data);
    checkOutput({tag, "_exc"},    {31'd0, rexc}, {31'd0, exp_exc});
    checkOutput({tag, "_writes"}, 32'(writes), 32'(exp_writes));
    finishResp(tag);
  endtask

  initial begin
    int          lat;
    logic [31:0] rdata;
    logic [31:0] held;
    logic        rexc;
    int          writes;
    int          w0;
    int          n;

    RESET                 = 1'b0;
    core_bus.req_valid    = 1'b0;
    core_bus.req_store    = 1'b0;
    core_bus.req_size     = 2'd0;
    core_bus.req_unsigned = 1'b0;
    core_bus.req_address  = 32'd0;
    core_bus.req_data     = 32'd0;
    core_bus.resp_ready   = 1'b1;
    mem_read_exception    = 1'b0;
    mem_write_exception   = 1'b0;
    load_en               = 1'b1;
    load_idx              = 10'h040;
    load_val              = 32'h8899_AABB;

    // Reset values, with a preload of word 0x100 while reset is held
    @(posedge CLK); #1;
    load_en = 1'b0;
    checkOutput("rst_req_ready",  {31'd0, core_bus.req_ready},      32'd0);
    checkOutput("rst_resp_valid", {31'd0, core_bus.resp_valid},     32'd0);
    checkOutput("rst_resp_data",  core_bus.resp_data,               32'd0);
    checkOutput("rst_resp_exc",   {31'd0, core_bus.resp_exception}, 32'd0);
    checkOutput("rst_we",         {31'd0, mem_write_enable},        32'd0);
    checkOutput("rst_waddr",      mem_write_address,                32'd0);
    RESET = 1'b1;
    #1;
    checkOutput("rel_ready_before_edge", {31'd0, core_bus.req_ready}, 32'd0);
    @(posedge CLK); #1;
    checkOutput("rel_ready_after_edge", {31'd0, core_bus.req_ready}, 32'd1);

    // Loads from 0x8899AABB
    runCase("lb_103_s", 1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 2, 32'hFFFF_FF88, 1'b0, 0);
    runCase("lb_103_u", 1'b0, 2'd0, 1'b1, 32'h103, 32'd0, 2, 32'h0000_0088, 1'b0, 0);
    runCase("lb_101_s", 1'b0, 2'd0, 1'b0, 32'h101, 32'd0, 2, 32'hFFFF_FFAA, 1'b0, 0);
    runCase("lb_100_u", 1'b0, 2'd0, 1'b1, 32'h100, 32'd0, 2, 32'h0000_00BB, 1'b0, 0);
    runCase("lh_100_s", 1'b0, 2'd1, 1'b0, 32'h100, 32'd0, 2, 32'hFFFF_AABB, 1'b0, 0);
    runCase("lh_102_u", 1'b0, 2'd1, 1'b1, 32'h102, 32'd0, 2, 32'h0000_8899, 1'b0, 0);

    // Half store with read-modify-write, then read back
    runCase("sh_102", 1'b1, 2'd1, 1'b0, 32'h102, 32'hFFFF_1234, 3, 32'd0, 1'b0, 1);
    checkOutput("sh_102_waddr", wr_addr, 32'h100);
    checkOutput("sh_102_wdata", wr_data, 32'h1234_AABB);
    runCase("lw_100", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 2, 32'h1234_AABB, 1'b0, 0);

    // Word store skips the read phase
    runCase("sw_200", 1'b1, 2'd2, 1'b0, 32'h200, 32'hDEAD_BEEF, 2, 32'd0, 1'b0, 1);
    checkOutput("sw_200_waddr", wr_addr, 32'h200);
    checkOutput("sw_200_wdata", wr_data, 32'hDEAD_BEEF);

    // Byte store into lane 1, then read back
    runCase("sb_201", 1'b1, 2'd0, 1'b0, 32'h201, 32'h0000_005A, 3, 32'd0, 1'b0, 1);
    runCase("lw_200", 1'b0, 2'd2, 1'b0, 32'h200, 32'd0, 2, 32'hDEAD_5AEF, 1'b0, 0);

    // Misaligned and illegal-size requests
    runCase("lh_101_mis", 1'b0, 2'd1, 1'b0, 32'h101, 32'd0,         1, 32'd0, 1'b1, 0);
    runCase("sw_202_mis", 1'b1, 2'd2, 1'b0, 32'h202, 32'h1111_2222, 1, 32'd0, 1'b1, 0);
    runCase("sz3_100",    1'b0, 2'd3, 1'b0, 32'h100, 32'd0,         1, 32'd0, 1'b1, 0);
    checkOutput("mis_mem_200", mem[10'h080], 32'hDEAD_5AEF);

    // Memory read fault: load and sub-word store both report, store never writes
    mem_read_exception = 1'b1;
    runCase("lw_rdexc", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0,  2, 32'd0, 1'b1, 0);
    runCase("sb_rdexc", 1'b1, 2'd0, 1'b0, 32'h100, 32'hEE, 2, 32'd0, 1'b1, 0);
    mem_read_exception = 1'b0;

    // Memory write fault is folded into the response
    mem_write_exception = 1'b1;
    runCase("sw_wrexc", 1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFE_F00D, 2, 32'd0, 1'b1, 1);
    mem_write_exception = 1'b0;

    // Backpressure: five stalled cycles in RSP
    core_bus.resp_ready = 1'b0;
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, lat, rdata, rexc, writes);
    checkOutput("bp_lat",  32'(lat), 32'd2);
    checkOutput("bp_data", rdata, 32'h1234_AABB);
    held = rdata;
    w0   = wr_count;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      checkOutput("bp_valid", {31'd0, core_bus.resp_valid}, 32'd1);
      checkOutput("bp_hold",  core_bus.resp_data, held);
      checkOutput("bp_ready", {31'd0, core_bus.req_ready}, 32'd0);
      checkOutput("bp_nowr",  32'(wr_count - w0), 32'd0);
    end
    finishResp("bp");
    checkOutput("bp_idle_ready", {31'd0, core_bus.req_ready}, 32'd1);

    // Reset during WR of a byte store
    core_bus.req_valid    = 1'b1;
    core_bus.req_store    = 1'b1;
    core_bus.req_size     = 2'd0;
    core_bus.req_unsigned = 1'b0;
    core_bus.req_address  = 32'h100;
    core_bus.req_data     = 32'h77;
    @(posedge CLK); #1;
    core_bus.req_valid = 1'b0;
    n = 0;
    while (!mem_write_enable && n < 10) begin
      @(posedge CLK); #1;
      n++;
    end
    checkOutput("rstwr_reached_wr", {31'd0, mem_write_enable}, 32'd1);
    w0    = wr_count;
    RESET = 1'b0;
    #1;
    checkOutput("rstwr_we",         {31'd0, mem_write_enable},        32'd0);
    checkOutput("rstwr_req_ready",  {31'd0, core_bus.req_ready},      32'd0);
    checkOutput("rstwr_resp_valid", {31'd0, core_bus.resp_valid},     32'd0);
    checkOutput("rstwr_resp_exc",   {31'd0, core_bus.resp_exception}, 32'd0);
    checkOutput("rstwr_wdata",      mem_write_data,                   32'd0);
    checkOutput("rstwr_raddr",      mem_read_address,                 32'd0);
    @(posedge CLK); #1;
    checkOutput("rstwr_mem",    mem[10'h040], 32'h1234_AABB);
    checkOutput("rstwr_writes", 32'(wr_count - w0), 32'd0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    runCase("post_rst_lw", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 2, 32'h1234_AABB, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_subword_adapter.md
Name: mem_subword_adapter

Overview:
- Sits directly upstream of the 32-bit memory model, between the core's load/store path and the memory's read/write ports.
- Converts core byte, halfword and word loads and stores into aligned 32-bit word accesses.
- Loads: extracts the addressed lane and sign- or zero-extends it.
- Sub-word stores: performs read-modify-write, because the memory only writes whole words.
- Detects misalignment and forwards memory exceptions, over a valid/ready request/response handshake.

Parameters:
- ADDR_WIDTH, 32, width of the byte address on both the core and memory sides.
- WORD_STORE_SKIP_READ, 1, when 1 a full-word store skips the read phase (no RMW).

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- req_valid  input  1  core request valid.
- req_ready  output  1  adapter can accept a request.
- req_store  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_address  input  ADDR_WIDTH  byte address.
- req_data  input  32  store data, right-justified.
- resp_valid  output  1  response valid.
- resp_ready  input  1  core accepts the response.
- resp_data  output  32  extended load data; 0 for stores.
- resp_exception  output  1  misaligned, illegal size, or memory exception.
- mem_read_address  output  ADDR_WIDTH  word-aligned read address.
- mem_read_data  input  32  combinational read data from memory.
- mem_read_exception  input  1  memory read fault.
- mem_write_enable  output  1  one-cycle write strobe.
- mem_write_address  output  ADDR_WIDTH  word-aligned write address.
- mem_write_data  output  32  merged word.
- mem_write_exception  input  1  memory write fault.

Behaviour:
- Reset (RESET low):
  - Takes effect asynchronously and holds state IDLE.
  - req_ready=0 while RESET is low; it rises on the first edge after release.
  - resp_valid=0, resp_data=0, resp_exception=0, mem_write_enable=0, address/data registers=0.
  - Reset mid-operation abandons the request. mem_write_enable drops immediately, so no partial write is issued.
- States: IDLE, RD, WR, RSP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, the adapter latches the request.
  - aligned_addr = {address[ADDR_WIDTH-1:2], 2'b00}; lane = address[1:0].
  - Error check (no memory access, go to RSP with resp_exception=1, resp_data=0): size==3, half with lane[0]=1, or word with lane!=0.
  - Otherwise the next state is RD, or WR for a word store when WORD_STORE_SKIP_READ=1.
- mem_read_address:
  - Driven from the latched aligned_addr in every state.
  - Value in IDLE is don't-care, but must be stable.
- RD (exactly one cycle):
  - At the rising edge ending RD, the adapter captures mem_read_data and mem_read_exception.
  - On a read exception: RSP with resp_exception=1, and no write.
  - Load: compute resp_data, then go to RSP.
    - Byte: lane selects bits [8*lane+7:8*lane].
    - Half: lane 0 selects [15:0], lane 2 selects [31:16].
    - Extension per req_unsigned.
  - Store: form the merged word by replacing only the addressed byte/half lane with req_data[7:0]/[15:0], then go to WR.
- WR (exactly one cycle):
  - mem_write_enable=1, mem_write_address=aligned_addr, mem_write_data=merged (or req_data for a skipped-read word store).
  - mem_write_exception is sampled at the edge ending WR and ORed into resp_exception.
  - Next state RSP.
- RSP:
  - resp_valid=1; resp_data and resp_exception held stable until resp_ready.
  - On resp_valid&&resp_ready, return to IDLE; resp_valid drops on that edge.
  - The next request cannot be accepted in the same cycle.
- Latency (request accept edge to resp_valid):
  - Load: 2 cycles.
  - Sub-word store: 3 cycles.
  - Skipped-read word store: 2 cycles.
  - Error: 1 cycle.
- Backpressure: resp_ready held low stalls in RSP indefinitely; no further memory traffic.
- Ordering: strictly one outstanding request. A store's write lands at the edge ending WR, so a following load to the same word observes it.
- Address wrap: aligned_addr arithmetic never adds offsets. The top address word is legal; no wrap handling is required.

Test Plan:
- Memory word 0x100 = 0x8899AABB; load byte addr 0x103 signed -> resp_data 0xFFFFFF88, 2 cycles after accept; unsigned -> 0x00000088.
- Store half 0x1234 to 0x102 over 0x8899AABB -> one RD cycle, then one WR cycle with data 0x1234AABB to 0x100; subsequent word load returns 0x1234AABB.
- Word store 0xDEADBEEF to 0x200 with WORD_STORE_SKIP_READ=1 -> WR in the cycle after accept, no RD; resp_valid 2 cycles after accept.
- Misalignment: half load at 0x101, word store at 0x202, size=3 -> resp_exception=1 one cycle after accept; mem_write_enable never asserted; memory unchanged.
- resp_ready held low 5 cycles in RSP -> resp_valid and resp_data stable, req_ready=0, no write strobes; the accepting edge returns to IDLE.
- RESET driven low during WR of a byte store -> mem_write_enable falls immediately; all outputs reset values; memory word unchanged; after release the first request completes normally.
